// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with run/stop control; scaled_clk and ticks are registered, one cycle after the deciding edge.
// New half-periods are staged and applied at the falling toggle; cfg_ready drops while one is staged, so the source must hold.
module clk_div_ctrl #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             scaled_clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] pend_half;
  logic             pend_valid;
  logic             cfg_xfer;
  logic             at_top;
  logic [CNT_W-1:0] exit_half;

  assign cfg_ready = !pend_valid;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE) || pend_valid;
  assign at_top    = (counter == cur_half);

  // On return to IDLE nothing may stay staged: a same-cycle transfer lands directly in cur_half.
  assign exit_half = pend_valid ? pend_half : (cfg_xfer ? cfg_half : cur_half);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      counter    <= '0;
      scaled_clk <= 1'b0;
      rise_tick  <= 1'b0;
      fall_tick  <= 1'b0;
      cur_half   <= CNT_W'(DEFAULT_HALF);
      pend_half  <= '0;
      pend_valid <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      case (state)
        IDLE: begin
          counter    <= '0;
          scaled_clk <= 1'b0;
          if (cfg_xfer) cur_half <= cfg_half;
          if (start && !stop) state <= RUN;
        end
        RUN, STOPPING: begin
          if (state == RUN && stop && !scaled_clk) begin
            state      <= IDLE;
            counter    <= '0;
            cur_half   <= exit_half;
            pend_valid <= 1'b0;
          end else if (at_top) begin
            counter    <= '0;
            scaled_clk <= ~scaled_clk;
            if (scaled_clk) begin
              fall_tick <= 1'b1;
              // A stop landing on the falling toggle is already a clean boundary.
              if (state == STOPPING || stop) begin
                state      <= IDLE;
                cur_half   <= exit_half;
                pend_valid <= 1'b0;
              end else if (pend_valid) begin
                cur_half   <= pend_half;
                pend_valid <= 1'b0;
              end else if (cfg_xfer) begin
                pend_half  <= cfg_half;
                pend_valid <= 1'b1;
              end
            end else begin
              rise_tick <= 1'b1;
              if (cfg_xfer) begin
                pend_half  <= cfg_half;
                pend_valid <= 1'b1;
              end
            end
          end else begin
            counter <= counter + CNT_W'(1);
            if (cfg_xfer) begin
              pend_half  <= cfg_half;
              pend_valid <= 1'b1;
            end
            if (state == RUN && stop) state <= STOPPING;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
